spart_tx: RTL and testbench

- Transmit half of the SPART serial port; the counterpart to the SPART receiver.
- Accepts a byte from the processor-side bus and serializes it onto TX as an async frame: 1 start bit (0), DATA_BITS data bits, STOP_BITS stop bits (1).
- Bit timing comes from the shared baud-rate generator's brg_en tick (one tick = one bit period).
- One-entry holding buffer in front of the shift register, so back-to-back frames send with no idle gap.

---
 rtl/spart_tx_if.sv | 13 +
 rtl/spart_tx.sv | 107 ++++++++++
 tb/tb_spart_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spart_tx_if.sv
// Processor-side bus and serial-line signals of the SPART transmitter.
// The master drives the byte, load strobe and bit tick; the slave is the transmitter.
interface spart_tx_if;
    logic       brg_en;
    logic [7:0] DATABUS;
    logic       tx_load;
    logic       TBR;
    logic       tx_busy;
    logic       TX;

    modport master (output brg_en, DATABUS, tx_load, input TBR, tx_busy, TX);
    modport slave  (input brg_en, DATABUS, tx_load, output TBR, tx_busy, TX);
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: a one-byte holding register feeding a shift register that
// serializes start, data and stop bits onto TX, one bit per brg_en tick.
module spart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input logic       clk,
    input logic       rst,
    spart_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_adv;
    logic [2:0]           bit_cnt;
    logic [0:0]           stop_cnt;
    logic                 tbr_q;
    logic                 busy_q;
    logic                 tx_q;
    logic                 hold_valid;
    logic                 first_bit;
    logic                 last_stop;
    logic                 start_frame;

    assign hold_valid = ~tbr_q;
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));

    // A frame starts from IDLE or straight out of the final stop bit, which
    // is what lets queued bytes go out with no idle gap.
    assign start_frame = bus.brg_en && hold_valid &&
                         (state == IDLE || (state == STOP && last_stop));

    always_comb begin
        first_bit = shift[0];
        shift_adv = {1'b0, shift[DATA_BITS-1:1]};
        if (LSB_FIRST == 0) begin
            first_bit = shift[DATA_BITS-1];
            shift_adv = {shift[DATA_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            tbr_q    <= 1'b1;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            // Loads and hold->shift transfers never coincide: a load needs
            // TBR=1, a transfer needs TBR=0.
            if (bus.tx_load && tbr_q) begin
                hold  <= bus.DATABUS[DATA_BITS-1:0];
                tbr_q <= 1'b0;
            end
            if (start_frame) begin
                shift    <= hold;
                tbr_q    <= 1'b1;
                tx_q     <= 1'b0;
                bit_cnt  <= '0;
                stop_cnt <= '0;
                busy_q   <= 1'b1;
                state    <= START;
            end else if (bus.brg_en) begin
                case (state)
                    IDLE: tx_q <= 1'b1;
                    START: begin
                        tx_q  <= first_bit;
                        shift <= shift_adv;
                        state <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            tx_q     <= 1'b1;
                            stop_cnt <= '0;
                            state    <= STOP;
                        end else begin
                            tx_q    <= first_bit;
                            shift   <= shift_adv;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    STOP: begin
                        if (!last_stop) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.TX      = tx_q;
    assign bus.TBR     = tbr_q;
    assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: two instances (8N1 LSB-first, 8N2 MSB-first) checked every
// cycle against a queue-based line model, plus directed frame-pattern checks.
module tb_spart_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spart_tx_if ifa ();
    spart_tx_if ifb ();

    spart_tx #(.DATA_BITS(8), .STOP_BITS(1), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    spart_tx #(.DATA_BITS(8), .STOP_BITS(2), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bit-period tick: one cycle high every 4 clocks.
    int brg_cnt = 0;
    initial begin
        ifa.brg_en = 1'b0;
        ifb.brg_en = 1'b0;
        forever begin
            @(negedge clk);
            brg_cnt    = (brg_cnt == 3) ? 0 : brg_cnt + 1;
            ifa.brg_en = (brg_cnt == 0);
            ifb.brg_en = (brg_cnt == 0);
        end
    end

    // Line model: an accepted byte waits in a one-slot buffer, then becomes a
    // queue of line bits; each tick puts the next queued bit on the line.
    bit         m_hv   [2];
    logic [7:0] m_hold [2];
    bit         m_busy [2];
    bit         m_tx   [2];
    bit         line_q [2][$];

    task automatic model_step(input int d);
        bit tick, ld, pre;
        logic [7:0] db;
        tick = (d == 1) ? ifb.brg_en  : ifa.brg_en;
        ld   = (d == 1) ? ifb.tx_load : ifa.tx_load;
        db   = (d == 1) ? ifb.DATABUS : ifa.DATABUS;
        if (rst) begin
            m_hv[d] = 1'b0; m_busy[d] = 1'b0; m_tx[d] = 1'b1;
            line_q[d].delete();
        end else begin
            pre = m_hv[d];
            if (tick) begin
                if (line_q[d].size() > 0) begin
                    m_tx[d] = line_q[d].pop_front();
                end else if (m_hv[d]) begin
                    line_q[d].push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        line_q[d].push_back((d == 0) ? m_hold[d][i] : m_hold[d][7-i]);
                    for (int i = 0; i < d + 1; i++) line_q[d].push_back(1'b1);
                    m_tx[d]   = line_q[d].pop_front();
                    m_hv[d]   = 1'b0;
                    m_busy[d] = 1'b1;
                end else begin
                    m_tx[d]   = 1'b1;
                    m_busy[d] = 1'b0;
                end
            end
            if (ld && !pre) begin
                m_hold[d] = db;
                m_hv[d]   = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            chk("a_tx",   ifa.TX,      m_tx[0]);
            chk("a_tbr",  ifa.TBR,     !m_hv[0]);
            chk("a_busy", ifa.tx_busy, m_busy[0]);
            chk("b_tx",   ifb.TX,      m_tx[1]);
            chk("b_tbr",  ifb.TBR,     !m_hv[1]);
            chk("b_busy", ifb.tx_busy, m_busy[1]);
        end
    end

    // Returns on the negedge after the next clock edge that had brg_en high.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!ifa.brg_en && n < 50);
        if (!ifa.brg_en) chk("tick_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic load_a(input logic [7:0] v);
        ifa.DATABUS = v; ifa.tx_load = 1'b1;
        @(negedge clk);
        ifa.tx_load = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        ifb.DATABUS = v; ifb.tx_load = 1'b1;
        @(negedge clk);
        ifb.tx_load = 1'b0;
    endtask

    logic [19:0] got;
    int r;

    initial begin
        rst = 1'b1;
        ifa.tx_load = 1'b0; ifa.DATABUS = '0;
        ifb.tx_load = 1'b0; ifb.DATABUS = '0;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        chk("rst_tx",   ifa.TX, 1);
        chk("rst_tbr",  ifa.TBR, 1);
        chk("rst_busy", ifa.tx_busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            wait_tick();
            chk("idle_tx", ifa.TX, 1);
            chk("idle_busy", ifa.tx_busy, 0);
        end

        // 0xA5, 8N1 LSB first
        wait_tick();
        load_a(8'hA5);
        chk("a5_tbr_lo", ifa.TBR, 0);
        got = '0;
        for (int i = 0; i < 10; i++) begin
            wait_tick();
            got = {got[18:0], ifa.TX};
            if (i == 0) chk("a5_tbr_xfer", ifa.TBR, 1);
        end
        chk("a5_frame", got[9:0], 10'b0101001011);
        wait_tick();
        chk("a5_idle", ifa.tx_busy, 0);

        // 0x3C then 0xFF queued mid-frame: no idle gap
        wait_tick();
        load_a(8'h3C);
        got = '0;
        for (int i = 0; i < 20; i++) begin
            wait_tick();
            got = {got[18:0], ifa.TX};
            if (i == 4) begin
                chk("b2b_tbr_pre", ifa.TBR, 1);
                load_a(8'hFF);
                chk("b2b_tbr_lo", ifa.TBR, 0);
            end
            if (i == 10) chk("b2b_tbr_xfer", ifa.TBR, 1);
        end
        chk("b2b_frames", got, 20'b0001111001_0111111111);
        wait_tick();
        chk("b2b_idle", ifa.tx_busy, 0);

        // 0x22 offered while TBR=0 must be dropped
        wait_tick();
        load_a(8'h11);
        chk("ign_tbr_lo", ifa.TBR, 0);
        load_a(8'h22);
        got = '0;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            got = {got[18:0], ifa.TX};
            if (i == 0) chk("ign_tbr_xfer", ifa.TBR, 1);
        end
        chk("ign_frame", got[11:0], 12'b0100010001_11);
        chk("ign_idle", ifa.tx_busy, 0);

        // reset during the 4th data bit of 0x81
        wait_tick();
        load_a(8'h81);
        for (int i = 0; i < 5; i++) wait_tick();
        chk("rst_mid_busy_pre", ifa.tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx",   ifa.TX, 1);
        chk("rst_mid_tbr",  ifa.TBR, 1);
        chk("rst_mid_busy", ifa.tx_busy, 0);
        rst = 1'b0;
        got = '0;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            got = {got[18:0], ifa.TX};
        end
        chk("rst_no_residual", got[11:0], 12'hFFF);
        chk("rst_after_busy", ifa.tx_busy, 0);

        // 0x80 on the 2-stop, MSB-first instance
        wait_tick();
        load_b(8'h80);
        got = '0;
        for (int i = 0; i < 11; i++) begin
            wait_tick();
            got = {got[18:0], ifb.TX};
        end
        chk("msb2_frame", got[10:0], 11'b01000000011);
        wait_tick();
        chk("msb2_idle", ifb.tx_busy, 0);

        // random loads, occasional resets; per-cycle model checks do the work
        for (int it = 0; it < 400; it++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            r = $urandom_range(0, 3);
            ifa.tx_load = r[0]; ifa.DATABUS = 8'($urandom);
            ifb.tx_load = r[1]; ifb.DATABUS = 8'($urandom);
            @(negedge clk);
            ifa.tx_load = 1'b0; ifb.tx_load = 1'b0;
            ifa.DATABUS = 8'($urandom); ifb.DATABUS = 8'($urandom);
        end
        repeat (100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
